// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter and the read-port scheduler.
package regfile_pkg;

    localparam int          ADDR_W    = 6;
    localparam int          DATA_W    = 32;
    localparam int unsigned ZERO_REG  = 32'd0;
    localparam int          SEL_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [SEL_IDX_W-1:0] idx;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
    } port_sel_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_chk.sv
// Simulation checker: the two write ports never target the same register in one cycle.
module regfile_wb_arbiter_chk #(
    parameter int ADDR_W = 6
) (
    input logic              clk,
    input logic              rst,
    input logic              we_a,
    input logic              we_b,
    input logic [ADDR_W-1:0] addr_a,
    input logic [ADDR_W-1:0] addr_b
);

    a_distinct_ports: assert property (@(posedge clk) disable iff (rst)
        (we_a && we_b) |-> (addr_a != addr_b));

endmodule

// File: rtl/rr_find_first.sv
// Rotating priority search: first set bit of req at or after start, wrapping mod N.
module rr_find_first #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Linear scan from start; the first hit wins and later hits are ignored.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            j = ((int'(start) + i) >= N) ? (int'(start) + i - N) : (int'(start) + i);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing register-file write ports A/B among NUM_REQ writeback requesters.
// Optional statistics counters are enabled with `define WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      we_a,
    output logic [ADDR_W-1:0]         addr_a,
    output logic [DATA_W-1:0]         data_a,
    output logic                      we_b,
    output logic [ADDR_W-1:0]         addr_b,
    output logic [DATA_W-1:0]         data_b,
    output logic                      wb_busy
`ifdef WB_ARB_STATS_EN
   ,output logic [15:0]               conflict_cnt,
    output logic [15:0]               grant_cnt
`endif
);
    import regfile_pkg::*;

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0]  addr_s [NUM_REQ];
    logic [DATA_W-1:0]  data_s [NUM_REQ];
    logic [NUM_REQ-1:0] nz_s;
    logic [NUM_REQ-1:0] zero_s;
    logic [NUM_REQ-1:0] conf_s;
    logic [NUM_REQ-1:0] mask_b_s;
    logic [NUM_REQ-1:0] a_oh_s;
    logic [NUM_REQ-1:0] b_oh_s;
    logic               a_found_s;
    logic               b_found_s;
    logic [IDX_W-1:0]   a_idx_s;
    logic [IDX_W-1:0]   b_idx_s;
    logic [ADDR_W-1:0]  a_addr_s;
    logic               skip_s;
    logic               gnt_a_s;
    logic               gnt_b_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   ptr_nxt_s;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return i + IDX_W'(1);
        end
    endfunction

    // Unpack requester lanes and split them into zero-register and real writes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_s[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_s[i] = req_data[i*DATA_W +: DATA_W];
            nz_s[i]   = req_valid[i] && (addr_s[i] != ZERO_ADDR);
            zero_s[i] = req_valid[i] && (addr_s[i] == ZERO_ADDR);
        end
    end

    rr_find_first #(.N(NUM_REQ), .IDX_W(IDX_W)) u_find_a (
        .req   (nz_s),
        .start (rr_ptr_r),
        .found (a_found_s),
        .idx   (a_idx_s)
    );

    assign a_addr_s = addr_s[a_idx_s];

    // Anything aiming at port A's register (A itself included) is kept off port B.
    always_comb begin
        a_oh_s = {NUM_REQ{1'b0}};
        if (a_found_s) begin
            a_oh_s[a_idx_s] = 1'b1;
        end else begin
            a_oh_s = {NUM_REQ{1'b0}};
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            conf_s[i] = a_found_s && nz_s[i] && (addr_s[i] == a_addr_s);
        end
        mask_b_s = nz_s & ~conf_s;
        skip_s   = |(conf_s & ~a_oh_s);
    end

    rr_find_first #(.N(NUM_REQ), .IDX_W(IDX_W)) u_find_b (
        .req   (mask_b_s),
        .start (rr_ptr_r),
        .found (b_found_s),
        .idx   (b_idx_s)
    );

    // Grants, handshake and next round-robin pointer.
    always_comb begin
        b_oh_s = {NUM_REQ{1'b0}};
        if (b_found_s) begin
            b_oh_s[b_idx_s] = 1'b1;
        end else begin
            b_oh_s = {NUM_REQ{1'b0}};
        end
        gnt_a_s = a_found_s && !wb_hold;
        gnt_b_s = b_found_s && !wb_hold;
        if (rst || wb_hold) begin
            req_ready = {NUM_REQ{1'b0}};
        end else begin
            req_ready = zero_s | a_oh_s | b_oh_s;
        end
        if (gnt_b_s) begin
            ptr_nxt_s = inc_wrap(b_idx_s);
        end else if (gnt_a_s) begin
            ptr_nxt_s = inc_wrap(a_idx_s);
        end else begin
            ptr_nxt_s = rr_ptr_r;
        end
    end

    // Registered write-port drive; address/data hold when a port is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_a     <= 1'b0;
            addr_a   <= {ADDR_W{1'b0}};
            data_a   <= {DATA_W{1'b0}};
            we_b     <= 1'b0;
            addr_b   <= {ADDR_W{1'b0}};
            data_b   <= {DATA_W{1'b0}};
            rr_ptr_r <= {IDX_W{1'b0}};
        end else begin
            we_a     <= gnt_a_s;
            we_b     <= gnt_b_s;
            rr_ptr_r <= ptr_nxt_s;
            if (gnt_a_s) begin
                addr_a <= a_addr_s;
                data_a <= data_s[a_idx_s];
            end
            if (gnt_b_s) begin
                addr_b <= addr_s[b_idx_s];
                data_b <= data_s[b_idx_s];
            end
        end
    end

    assign wb_busy = we_a | we_b;

`ifdef WB_ARB_STATS_EN
    logic [1:0] gnt_num_s;
    assign gnt_num_s = {1'b0, gnt_a_s} + {1'b0, gnt_b_s};

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 16'd0;
            grant_cnt    <= 16'd0;
        end else begin
            conflict_cnt <= sat_add16(conflict_cnt, {1'b0, skip_s && !wb_hold});
            grant_cnt    <= sat_add16(grant_cnt, gnt_num_s);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

    logic         clk;
    logic         rst;
    logic         wb_hold;
    logic [3:0]   req_valid;
    logic [23:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         we_a;
    logic [5:0]   addr_a;
    logic [31:0]  data_a;
    logic         we_b;
    logic [5:0]   addr_b;
    logic [31:0]  data_b;
    logic         wb_busy;
`ifdef WB_ARB_STATS_EN
    logic [15:0]  conflict_cnt;
    logic [15:0]  grant_cnt;
`endif

    int n_cmp;
    int n_err;
    int gnt_count [4];

    regfile_wb_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_hold      (wb_hold),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .we_a         (we_a),
        .addr_a       (addr_a),
        .data_a       (data_a),
        .we_b         (we_b),
        .addr_b       (addr_b),
        .data_b       (data_b),
        .wb_busy      (wb_busy)
`ifdef WB_ARB_STATS_EN
       ,.conflict_cnt (conflict_cnt),
        .grant_cnt    (grant_cnt)
`endif
    );

    regfile_wb_arbiter_chk #(.ADDR_W(6)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .we_a   (we_a),
        .we_b   (we_b),
        .addr_a (addr_a),
        .addr_b (addr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
        req_valid[i]           = 1'b1;
        req_addr[i*6 +: 6]     = a;
        req_data[i*32 +: 32]   = d;
    endtask

    task automatic clr_req();
        req_valid = 4'b0000;
        req_addr  = 24'd0;
        req_data  = 128'd0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        wb_hold = 1'b0;
        clr_req();
        for (int i = 0; i < 4; i++) gnt_count[i] = 0;

        // Reset state, ready held low while rst is high
        tick();
        set_req(0, 6'd5, 32'h1);
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'h0);
        check_eq("rst_we_a", 64'(we_a), 64'h0);
        check_eq("rst_we_b", 64'(we_b), 64'h0);
        check_eq("rst_addr_a", 64'(addr_a), 64'h0);
        check_eq("rst_data_b", 64'(data_b), 64'h0);
        tick();
        rst = 1'b0;
        clr_req();

        // Two requesters, rr_ptr=0
        set_req(0, 6'd5, 32'hAAAA0000);
        set_req(2, 6'd9, 32'h12345678);
        #1;
        check_eq("two_ready", 64'(req_ready), 64'h5);
        tick();
        clr_req();
        check_eq("two_we_a", 64'(we_a), 64'h1);
        check_eq("two_addr_a", 64'(addr_a), 64'd5);
        check_eq("two_data_a", 64'(data_a), 64'hAAAA0000);
        check_eq("two_we_b", 64'(we_b), 64'h1);
        check_eq("two_addr_b", 64'(addr_b), 64'd9);
        check_eq("two_data_b", 64'(data_b), 64'h12345678);
        check_eq("two_busy", 64'(wb_busy), 64'h1);

        // rr_ptr must now be 3: requester 3 wins port A over requester 0
        set_req(0, 6'd10, 32'h0A0A0A0A);
        set_req(3, 6'd11, 32'h0B0B0B0B);
        #1;
        check_eq("ptr3_ready", 64'(req_ready), 64'h9);
        tick();
        clr_req();
        check_eq("ptr3_addr_a", 64'(addr_a), 64'd11);
        check_eq("ptr3_addr_b", 64'(addr_b), 64'd10);

        // Same-address conflict at rr_ptr=1
        set_req(1, 6'd7, 32'h11111111);
        set_req(3, 6'd7, 32'h33333333);
        #1;
        check_eq("conf_ready", 64'(req_ready), 64'h2);
        tick();
        check_eq("conf_we_a", 64'(we_a), 64'h1);
        check_eq("conf_addr_a", 64'(addr_a), 64'd7);
        check_eq("conf_data_a", 64'(data_a), 64'h11111111);
        check_eq("conf_we_b", 64'(we_b), 64'h0);
`ifdef WB_ARB_STATS_EN
        check_eq("conf_cnt", 64'(conflict_cnt), 64'd1);
        check_eq("conf_gcnt", 64'(grant_cnt), 64'd5);
`endif
        req_valid[1] = 1'b0;
        #1;
        check_eq("conf2_ready", 64'(req_ready), 64'h8);
        tick();
        clr_req();
        check_eq("conf2_we_a", 64'(we_a), 64'h1);
        check_eq("conf2_data_a", 64'(data_a), 64'h33333333);
        check_eq("conf2_we_b", 64'(we_b), 64'h0);

        // Zero register at rr_ptr=0
        set_req(0, 6'd0, 32'hDEADBEEF);
        set_req(1, 6'd3, 32'h00000003);
        set_req(2, 6'd4, 32'h00000004);
        #1;
        check_eq("zero_ready", 64'(req_ready), 64'h7);
        tick();
        clr_req();
        check_eq("zero_addr_a", 64'(addr_a), 64'd3);
        check_eq("zero_data_a", 64'(data_a), 64'h3);
        check_eq("zero_addr_b", 64'(addr_b), 64'd4);
        check_eq("zero_data_b", 64'(data_b), 64'h4);
        check_eq("zero_we_ab", 64'({we_a, we_b}), 64'h3);

        // Zero-register-only grant: no strobe, outputs held, rr_ptr stays 3
        set_req(0, 6'd0, 32'h55555555);
        #1;
        check_eq("zonly_ready", 64'(req_ready), 64'h1);
        tick();
        clr_req();
        check_eq("zonly_we_ab", 64'({we_a, we_b}), 64'h0);
        check_eq("zonly_addr_a", 64'(addr_a), 64'd3);
        check_eq("zonly_busy", 64'(wb_busy), 64'h0);

        // Hold for three cycles with everyone valid
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 6'(21 + i), 32'(32'h100 + i));
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("hold_ready", 64'(req_ready), 64'h0);
            tick();
            check_eq("hold_we_ab", 64'({we_a, we_b}), 64'h0);
        end
        wb_hold = 1'b0;
        #1;
        check_eq("rel_ready", 64'(req_ready), 64'h9);
        tick();
        check_eq("rel_addr_a", 64'(addr_a), 64'd24);
        check_eq("rel_addr_b", 64'(addr_b), 64'd21);
        check_eq("rel_we_a", 64'(we_a), 64'h1);

        // Reset mid-cycle while writes are pending
        rst = 1'b1;
        #1;
        check_eq("mid_we_ab", 64'({we_a, we_b}), 64'h0);
        check_eq("mid_addr_a", 64'(addr_a), 64'd0);
        check_eq("mid_ready", 64'(req_ready), 64'h0);
        tick();
        check_eq("mid_we_ab2", 64'({we_a, we_b}), 64'h0);
        rst = 1'b0;

        // Fairness from rr_ptr=0 with all four requesters continuously valid
        for (int c = 0; c < 8; c++) begin
            #1;
            check_eq("fair_ready", 64'(req_ready), (c % 2 == 0) ? 64'h3 : 64'hC);
            for (int i = 0; i < 4; i++) gnt_count[i] += int'(req_ready[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) check_eq("fair_count", 64'(gnt_count[i]), 64'd4);
        check_eq("fair_addr_a", 64'(addr_a), 64'd23);
        check_eq("fair_addr_b", 64'(addr_b), 64'd24);
`ifdef WB_ARB_STATS_EN
        check_eq("fair_ccnt", 64'(conflict_cnt), 64'd0);
        check_eq("fair_gcnt", 64'(grant_cnt), 64'd16);
`endif
        clr_req();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
